// File: rtl/sw_pkg.sv
// Stopwatch shared types and constants.
// Used by the controller and its divider.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/sw_ctrl_tick_gen.sv
// Programmable divider: strobes tick once every num enabled cycles.
// num of 0 or 1 strobes every enabled cycle.
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] num,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W:0]   w_inc;
  logic             w_wrap;

  // count+1 >= num covers num==0 without underflowing num-1
  assign w_inc  = {1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign w_wrap = w_inc >= {1'b0, num};
  assign tick   = en & ~clr & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : w_inc[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch controller: run/pause FSM, h:m:s chain, lap capture.
// The divider strobe advances the chain on the edge it asserts.
module sw_ctrl #(
  parameter int DIV_W    = 32,
  parameter int SEC_MAX  = sw_pkg::SEC_MAX,
  parameter int MIN_MAX  = sw_pkg::MIN_MAX,
  parameter int HOUR_MAX = sw_pkg::HOUR_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  input  logic             start,
  input  logic             clr,
  input  logic             lap,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic [4:0]       hour,
  output logic [5:0]       lap_sec,
  output logic [5:0]       lap_min,
  output logic [4:0]       lap_hour,
  output logic             lap_valid,
  output logic             running,
  output logic             tick
);

  import sw_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   w_run_d;
  logic   r_running;
  logic   r_tick;
  logic   w_tick;
  logic   w_en;
  logic   w_lap;

  logic [SEC_W-1:0]  r_sec;
  logic [MIN_W-1:0]  r_min;
  logic [HOUR_W-1:0] r_hour;
  logic [SEC_W-1:0]  r_lsec;
  logic [MIN_W-1:0]  r_lmin;
  logic [HOUR_W-1:0] r_lhour;
  logic              r_lap_valid;

  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;

  assign w_en  = (r_state == RUN);
  assign w_lap = lap & w_en & ~clr;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_en),
    .clr  (clr),
    .num  (num),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= w_run_d;
    end
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = IDLE;
    end else if (start) begin
      case (r_state)
        IDLE:    w_next = RUN;
        RUN:     w_next = PAUSE;
        PAUSE:   w_next = RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_run_d = (w_next == RUN);
  end

  assign w_sec_wrap  = (r_sec == SEC_W'(SEC_MAX));
  assign w_min_wrap  = (r_min == MIN_W'(MIN_MAX));
  assign w_hour_wrap = (r_hour == HOUR_W'(HOUR_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        if (w_sec_wrap) begin
          r_sec <= '0;
          if (w_min_wrap) begin
            r_min  <= '0;
            r_hour <= w_hour_wrap ? '0 : r_hour + 1'b1;
          end else begin
            r_min <= r_min + 1'b1;
          end
        end else begin
          r_sec <= r_sec + 1'b1;
        end
      end
    end
  end

  // capture uses pre-edge time, so a coincident tick is excluded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsec      <= '0;
      r_lmin      <= '0;
      r_lhour     <= '0;
      r_lap_valid <= 1'b0;
    end else if (clr) begin
      r_lsec      <= '0;
      r_lmin      <= '0;
      r_lhour     <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_valid <= w_lap;
      if (w_lap) begin
        r_lsec  <= r_sec;
        r_lmin  <= r_min;
        r_lhour <= r_hour;
      end
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hour      = r_hour;
  assign lap_sec   = r_lsec;
  assign lap_min   = r_lmin;
  assign lap_hour  = r_lhour;
  assign lap_valid = r_lap_valid;
  assign running   = r_running;
  assign tick      = r_tick;

endmodule

// File: tb/tb_sw_ctrl.sv
// Stopwatch controller bench: directed steps plus random pulses,
// checked each cycle against an elapsed-seconds reference model.
module tb_sw_ctrl;

  localparam int SM  = 59;
  localparam int MM  = 59;
  localparam int HM  = 2;
  localparam int DAY = (SM + 1) * (MM + 1) * (HM + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num = 32'd0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        lap = 1'b0;
  logic [5:0]  sec, min, lap_sec, lap_min;
  logic [4:0]  hour, lap_hour;
  logic        lap_valid, running, tick;

  int checks = 0;
  int errors = 0;

  int     m_st;
  int     m_t;
  int     m_lap_t;
  longint m_div;
  bit     m_lapv;
  bit     m_tick;

  sw_ctrl #(
    .DIV_W   (32),
    .SEC_MAX (SM),
    .MIN_MAX (MM),
    .HOUR_MAX(HM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (num),
    .start    (start),
    .clr      (clr),
    .lap      (lap),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .lap_sec  (lap_sec),
    .lap_min  (lap_min),
    .lap_hour (lap_hour),
    .lap_valid(lap_valid),
    .running  (running),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st    = 0;
    m_t     = 0;
    m_lap_t = 0;
    m_div   = 0;
    m_lapv  = 0;
    m_tick  = 0;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit l);
    bit tk;
    if (c) begin
      model_reset();
    end else begin
      tk = (m_st == 1) && (m_div + 1 >= longint'(num));
      m_lapv = (m_st == 1) && l;
      if (m_lapv) m_lap_t = m_t;
      if (m_st == 1) m_div = tk ? 0 : m_div + 1;
      if (tk) m_t = (m_t + 1) % DAY;
      m_tick = tk;
      if (s) m_st = (m_st == 1) ? 2 : 1;
    end
  endtask

  task automatic check_all();
    chk("sec", 32'(sec), 32'(m_t % (SM + 1)));
    chk("min", 32'(min), 32'((m_t / (SM + 1)) % (MM + 1)));
    chk("hour", 32'(hour), 32'(m_t / ((SM + 1) * (MM + 1))));
    chk("lap_sec", 32'(lap_sec), 32'(m_lap_t % (SM + 1)));
    chk("lap_min", 32'(lap_min),
        32'((m_lap_t / (SM + 1)) % (MM + 1)));
    chk("lap_hour", 32'(lap_hour),
        32'(m_lap_t / ((SM + 1) * (MM + 1))));
    chk("lap_valid", 32'(lap_valid), 32'(m_lapv));
    chk("running", 32'(running), 32'(m_st == 1));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic cyc(input bit s, input bit c, input bit l);
    start = s;
    clr   = c;
    lap   = l;
    @(posedge clk);
    model_edge(s, c, l);
    #1;
    start = 1'b0;
    clr   = 1'b0;
    lap   = 1'b0;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  initial begin
    int r;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // first tick latency with num=4
    num = 32'd4;
    cyc(1, 0, 0);
    run(3);
    chk("t1_no_tick_yet", 32'(tick), 32'd0);
    cyc(0, 0, 0);
    chk("t1_first_tick", 32'(tick), 32'd1);
    chk("t1_sec1", 32'(sec), 32'd1);
    run(8);
    chk("t1_sec3", 32'(sec), 32'd3);
    chk("t1_running", 32'(running), 32'd1);

    // minute carry, then full-day wrap
    cyc(0, 1, 0);
    num = 32'd1;
    cyc(1, 0, 0);
    run(60);
    chk("t2_sec_wrap", 32'(sec), 32'd0);
    chk("t2_min_carry", 32'(min), 32'd1);
    run(DAY - 1 - 60);
    chk("t2_top_hour", 32'(hour), 32'(HM));
    chk("t2_top_min", 32'(min), 32'(MM));
    chk("t2_top_sec", 32'(sec), 32'(SM));
    cyc(0, 0, 0);
    chk("t2_day_wrap", 32'({hour, min, sec}), 32'd0);

    // pause keeps partial second
    cyc(0, 1, 0);
    num = 32'd10;
    cyc(1, 0, 0);
    run(5);
    cyc(1, 0, 0);
    run(20);
    chk("t3_paused_sec", 32'(sec), 32'd0);
    chk("t3_paused_run", 32'(running), 32'd0);
    cyc(1, 0, 0);
    run(3);
    chk("t3_resume_wait", 32'(tick), 32'd0);
    cyc(0, 0, 0);
    chk("t3_resume_tick", 32'(tick), 32'd1);

    // lap on a tick cycle, then lap while paused
    cyc(0, 1, 0);
    num = 32'd1;
    cyc(1, 0, 0);
    run(5);
    num = 32'd4;
    run(3);
    cyc(0, 0, 1);
    chk("t4_lap_sec", 32'(lap_sec), 32'd5);
    chk("t4_live_sec", 32'(sec), 32'd6);
    chk("t4_lap_valid", 32'(lap_valid), 32'd1);
    cyc(1, 0, 0);
    chk("t4_lap_pulse", 32'(lap_valid), 32'd0);
    cyc(0, 0, 1);
    chk("t4_pause_lapv", 32'(lap_valid), 32'd0);
    chk("t4_pause_lap", 32'(lap_sec), 32'd5);

    // clr beats start at 00:01:07
    cyc(0, 1, 0);
    num = 32'd1;
    cyc(1, 0, 0);
    run(66);
    cyc(0, 0, 1);
    chk("t5_min", 32'(min), 32'd1);
    chk("t5_sec", 32'(sec), 32'd7);
    chk("t5_lap_sec", 32'(lap_sec), 32'd6);
    cyc(1, 1, 0);
    chk("t5_clr_time", 32'({hour, min, sec}), 32'd0);
    chk("t5_clr_lap", 32'({lap_hour, lap_min, lap_sec}), 32'd0);
    chk("t5_clr_run", 32'(running), 32'd0);

    // lowering num forces an immediate wrap
    num = 32'd100;
    cyc(1, 0, 0);
    run(50);
    num = 32'd20;
    cyc(0, 0, 0);
    chk("t6_forced_tick", 32'(tick), 32'd1);
    run(19);
    chk("t6_gap", 32'(tick), 32'd0);
    cyc(0, 0, 0);
    chk("t6_period", 32'(tick), 32'd1);

    // random pulses and divider changes
    repeat (600) begin
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) num = $urandom_range(0, 6);
      cyc(r == 0, r == 1, r == 2 || r == 3);
    end

    // asynchronous reset mid-run
    cyc(0, 1, 0);
    num = 32'd2;
    cyc(1, 0, 0);
    run(9);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_sec", 32'(sec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("t6_idle_after", 32'(running), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
